// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment Avalon-MM controller:
// register addresses, CTRL bit positions and the hex glyph table.
package sevseg_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DP     = 3'd1;
  localparam logic [2:0] ADDR_BLANK  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_LZS         = 1;
  localparam int CTRL_AUTO_COMMIT = 2;
  localparam int CTRL_COMMIT      = 31;

  typedef struct packed {
    logic auto_commit;
    logic lzs;
    logic enable;
  } ctrl_t;

  // Segment order {g,f,e,d,c,b,a}, active-high (lit = 1)
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/sevseg_avmm_ctrl_if.sv
// Avalon-MM slave bus bundle for the seven-segment controller.
interface sevseg_avmm_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/sevseg_blink_gen.sv
// Free-running blink phase generator. The counter wraps every
// HALF_PERIOD cycles and toggles the phase; i_restart forces both
// back to zero so a freshly enabled blink starts with a full lit interval.
module sevseg_blink_gen #(
  parameter int HALF_PERIOD = 25000000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic i_restart,
  output logic o_phase
);

  localparam int HP = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
  localparam int CW = (HP > 1) ? $clog2(HP) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  // Half-period counter with phase toggle on wrap
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CW'(HP - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/sevseg_avmm_ctrl.sv
// Seven-segment display controller, 1..8 digits, Avalon-MM slave.
// Shadow/active double-buffered DATA/DP/BLANK/BLINK, hex decode,
// leading-zero suppression and per-digit blink.
// Optional macro SEVSEG_SCAN_EN: time-multiplexed single-digit output
// with a one-hot digit select instead of parallel digit outputs.
module sevseg_avmm_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int SCAN_HZ    = 1000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  sevseg_avmm_ctrl_if.slave       avs,
`ifdef SEVSEG_SCAN_EN
  output logic [7:0]              sevseg_export,
  output logic [NUM_DIGITS-1:0]   sevseg_digit_sel
`else
  output logic [8*NUM_DIGITS-1:0] sevseg_export
`endif
);

  import sevseg_pkg::*;

  localparam int          HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam logic [31:0] DATA_MASK   = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
  localparam logic [7:0]  DIG_MASK    = 8'((16'd1 << NUM_DIGITS) - 16'd1);
  localparam logic [7:0]  SEG_OFF     = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [31:0] r_sh_data, r_ac_data, w_sh_data_nxt;
  logic [7:0]  r_sh_dp, r_ac_dp, w_sh_dp_nxt;
  logic [7:0]  r_sh_blank, r_ac_blank, w_sh_blank_nxt;
  logic [7:0]  r_sh_blink, r_ac_blink, w_sh_blink_nxt;
  ctrl_t       r_ctrl, w_ctrl_nxt;
  logic        w_commit;
  logic        w_blink_restart;
  logic        w_phase;
  logic        w_pending;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [7:0]  w_digit [NUM_DIGITS];
  logic [3:0]  w_nib;
  logic        w_zero_above;
  logic        w_dark;
  logic [7:0]  w_seg;

  // Shadow write decode and commit request
  always_comb begin
    w_sh_data_nxt  = r_sh_data;
    w_sh_dp_nxt    = r_sh_dp;
    w_sh_blank_nxt = r_sh_blank;
    w_sh_blink_nxt = r_sh_blink;
    w_ctrl_nxt     = r_ctrl;
    w_commit       = 1'b0;
    if (avs.avs_write) begin
      case (avs.avs_address)
        ADDR_DATA:  w_sh_data_nxt  = avs.avs_writedata & DATA_MASK;
        ADDR_DP:    w_sh_dp_nxt    = avs.avs_writedata[7:0] & DIG_MASK;
        ADDR_BLANK: w_sh_blank_nxt = avs.avs_writedata[7:0] & DIG_MASK;
        ADDR_BLINK: w_sh_blink_nxt = avs.avs_writedata[7:0] & DIG_MASK;
        ADDR_CTRL:  w_ctrl_nxt     = avs.avs_writedata[2:0];
        default:    ;
      endcase
      // Auto-commit publishes the value being written on the same edge
      if (avs.avs_address <= ADDR_BLINK)
        w_commit = r_ctrl.auto_commit;
      else if (avs.avs_address == ADDR_CTRL)
        w_commit = avs.avs_writedata[CTRL_COMMIT];
    end
    // Blink restarts when the active mask goes from empty to non-empty
    w_blink_restart = w_commit && (w_sh_blink_nxt != 8'h00) && (r_ac_blink == 8'h00);
  end

  // Shadow, active and control registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_sh_blink <= '0;
      r_ac_data  <= '0;
      r_ac_dp    <= '0;
      r_ac_blank <= '0;
      r_ac_blink <= '0;
      r_ctrl     <= '0;
    end else begin
      r_sh_data  <= w_sh_data_nxt;
      r_sh_dp    <= w_sh_dp_nxt;
      r_sh_blank <= w_sh_blank_nxt;
      r_sh_blink <= w_sh_blink_nxt;
      r_ctrl     <= w_ctrl_nxt;
      if (w_commit) begin
        r_ac_data  <= w_sh_data_nxt;
        r_ac_dp    <= w_sh_dp_nxt;
        r_ac_blank <= w_sh_blank_nxt;
        r_ac_blink <= w_sh_blink_nxt;
      end
    end
  end

  sevseg_blink_gen #(.HALF_PERIOD(HALF_PERIOD)) u_blink (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .i_restart     (w_blink_restart),
    .o_phase       (w_phase)
  );

  assign w_pending = (r_sh_data != r_ac_data) || (r_sh_dp != r_ac_dp) ||
                     (r_sh_blank != r_ac_blank) || (r_sh_blink != r_ac_blink);

  // Read mux; registers always return the shadow copy
  always_comb begin
    w_rdata_nxt = '0;
    case (avs.avs_address)
      ADDR_DATA:   w_rdata_nxt = r_sh_data;
      ADDR_DP:     w_rdata_nxt = {24'h0, r_sh_dp};
      ADDR_BLANK:  w_rdata_nxt = {24'h0, r_sh_blank};
      ADDR_BLINK:  w_rdata_nxt = {24'h0, r_sh_blink};
      ADDR_CTRL:   w_rdata_nxt = {29'h0, r_ctrl};
      ADDR_STATUS: w_rdata_nxt = {30'h0, w_pending, w_phase};
      default:     w_rdata_nxt = '0;
    endcase
  end

  // Read data register, latency 1, holds between reads
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      r_rdata <= '0;
    else if (avs.avs_read)
      r_rdata <= w_rdata_nxt;
  end

  assign avs.avs_readdata = r_rdata;

  // Per-digit glyph and dark decision; walks from the top digit down so
  // the leading-zero run is known when each digit is evaluated
  always_comb begin
    w_zero_above = 1'b1;
    w_nib        = '0;
    w_dark       = 1'b0;
    w_seg        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_nib        = r_ac_data[4*i +: 4];
      w_zero_above = w_zero_above & (w_nib == 4'h0);
      w_dark       = !r_ctrl.enable || r_ac_blank[i] || (r_ac_blink[i] && w_phase) ||
                     (r_ctrl.lzs && (i > 0) && w_zero_above);
      w_seg        = w_dark ? 8'h00 : {r_ac_dp[i], hex7seg(w_nib)};
      w_digit[i]   = ACTIVE_LOW ? ~w_seg : w_seg;
    end
  end

`ifdef SEVSEG_SCAN_EN
  localparam int SCAN_RAW = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int SEL_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [31:0]           r_scan_cnt;
  logic [SEL_W-1:0]      r_sel, w_sel_nxt;
  logic                  w_scan_tick;
  logic [7:0]            r_export;
  logic [NUM_DIGITS-1:0] r_digit_sel, w_onehot;

  // Scan position advance
  always_comb begin
    w_scan_tick = (r_scan_cnt == 32'(SCAN_DIV - 1));
    w_sel_nxt   = r_sel;
    if (w_scan_tick)
      w_sel_nxt = (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + 1'b1;
    w_onehot = NUM_DIGITS'(1) << w_sel_nxt;
  end

  // Scan counter and registered single-digit outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_scan_cnt  <= '0;
      r_sel       <= '0;
      r_export    <= SEG_OFF;
      r_digit_sel <= ACTIVE_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
    end else begin
      r_scan_cnt  <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
      r_sel       <= w_sel_nxt;
      r_export    <= w_digit[w_sel_nxt];
      r_digit_sel <= ACTIVE_LOW ? ~w_onehot : w_onehot;
    end
  end

  assign sevseg_export    = r_export;
  assign sevseg_digit_sel = r_digit_sel;
`else
  logic [8*NUM_DIGITS-1:0] r_export;

  // Registered parallel segment outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_export <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        r_export[8*i +: 8] <= w_digit[i];
    end
  end

  assign sevseg_export = r_export;
`endif

endmodule

// File: tb/tb_sevseg_avmm_ctrl.sv
// Bench for sevseg_avmm_ctrl: 8 digits, active-low, 10-cycle blink half period.
module tb_sevseg_avmm_ctrl;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] sevseg_export;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc;

  always #5 clk = ~clk;

  sevseg_avmm_ctrl_if avs_if ();

  sevseg_avmm_ctrl #(
    .NUM_DIGITS (8),
    .CLK_HZ     (100),
    .BLINK_HZ   (5),
    .ACTIVE_LOW (1'b1),
    .SCAN_HZ    (1)
  ) u_dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs           (avs_if.slave),
    .sevseg_export (sevseg_export)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Reference model: registers as words, glyphs from the standard 0-F set
  logic [31:0] m_sh [4];
  logic [31:0] m_ac [4];
  logic [2:0]  m_ctrl;
  int          m_base;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic void m_clear();
    for (int j = 0; j < 4; j++) begin m_sh[j] = 0; m_ac[j] = 0; end
    m_ctrl = 0;
    m_base = 0;
  endfunction

  function automatic int m_phase(int k);
    return ((k - m_base) / HALF) % 2;
  endfunction

  function automatic logic [63:0] m_export(int ph);
    logic [63:0] o;
    logic [3:0]  nib;
    logic [7:0]  b;
    logic        dark;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      nib  = 4'((m_ac[0] >> (4 * i)) & 32'hF);
      dark = !m_ctrl[0] || m_ac[2][i] || (m_ac[3][i] && ph == 1) ||
             (m_ctrl[1] && i > 0 && (m_ac[0] >> (4 * i)) == 0);
      b    = dark ? 8'h00 : {m_ac[1][i], glyph[nib]};
      o[8*i +: 8] = ~b;
    end
    return o;
  endfunction

  function automatic void m_apply(logic [2:0] a, logic [31:0] d, int at);
    logic [31:0] old_blink;
    old_blink = m_ac[3];
    if (a < 3'd4) begin
      m_sh[a] = (a == 3'd0) ? d : (d & 32'hFF);
      if (m_ctrl[2]) for (int j = 0; j < 4; j++) m_ac[j] = m_sh[j];
    end else if (a == 3'd4) begin
      if (d[31]) for (int j = 0; j < 4; j++) m_ac[j] = m_sh[j];
      m_ctrl = d[2:0];
    end
    if (old_blink == 0 && m_ac[3] != 0) m_base = at;
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a, int rcyc);
    logic pend;
    pend = 1'b0;
    for (int j = 0; j < 4; j++) if (m_sh[j] != m_ac[j]) pend = 1'b1;
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return m_sh[a];
      3'd4:    return {29'h0, m_ctrl};
      3'd5:    return {30'h0, pend, 1'(m_phase(rcyc - 1))};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_if.avs_address   = a;
    avs_if.avs_writedata = d;
    avs_if.avs_write     = 1'b1;
    @(posedge clk);
    #1;
    m_apply(a, d, cyc);
    @(negedge clk);
    avs_if.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int rcyc);
    @(negedge clk);
    avs_if.avs_address = a;
    avs_if.avs_read    = 1'b1;
    @(negedge clk);
    avs_if.avs_read = 1'b0;
    d    = avs_if.avs_readdata;
    rcyc = cyc;
  endtask

  task automatic chk_out(input string name);
    @(negedge clk);
    check(name, sevseg_export, m_export(m_phase(cyc - 1)));
  endtask

  task automatic chk_read(input string name, input logic [2:0] a);
    logic [31:0] d;
    int          rc;
    bus_read(a, d, rc);
    check(name, {32'h0, d}, {32'h0, m_read(a, rc)});
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] rd, old;
    int          rc;

    tbl[0] = '{3'd0, 32'h12345678, 32'h12345678};
    tbl[1] = '{3'd1, 32'h000001FF, 32'h000000FF};
    tbl[2] = '{3'd2, 32'hFFFFFFAA, 32'h000000AA};
    tbl[3] = '{3'd3, 32'h00000300, 32'h00000000};
    tbl[4] = '{3'd4, 32'h80000007, 32'h00000007};
    tbl[5] = '{3'd4, 32'h7FFFFFF9, 32'h00000001};
    tbl[6] = '{3'd6, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{3'd7, 32'h12345678, 32'h00000000};
    tbl[8] = '{3'd1, 32'h00000080, 32'h00000080};

    avs_if.avs_address = '0; avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = '0; avs_if.avs_read = 1'b0;
    m_clear();
    #13;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_export", sevseg_export, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_rdata", {32'h0, avs_if.avs_readdata}, 64'h0);
    chk_read("reset_ctrl", 3'd4);

    // Auto-commit display of 0x12345678
    bus_write(3'd4, 32'h5);
    bus_write(3'd0, 32'h12345678);
    @(negedge clk);
    check("plan1_export", sevseg_export, 64'hF9A4B099_9282F880);

    // Shadow write without commit, then explicit commit
    bus_write(3'd4, 32'h1);
    bus_write(3'd0, 32'h0000ABCD);
    @(negedge clk);
    check("plan2_held", sevseg_export, 64'hF9A4B099_9282F880);
    bus_read(3'd5, rd, rc);
    check("plan2_pending", {63'h0, rd[1]}, 64'h1);
    bus_write(3'd4, 32'h80000001);
    @(negedge clk);
    check("plan2_commit", sevseg_export, 64'hC0C0C0C0_8883C6A1);
    bus_read(3'd5, rd, rc);
    check("plan2_clear", {63'h0, rd[1]}, 64'h0);

    // Leading-zero suppression
    bus_write(3'd4, 32'h7);
    bus_write(3'd0, 32'h00000050);
    @(negedge clk);
    check("lzs_50", sevseg_export, 64'hFFFFFFFF_FFFF92C0);
    bus_write(3'd0, 32'h0);
    @(negedge clk);
    check("lzs_zero", sevseg_export, 64'hFFFFFFFF_FFFFFFC0);

    // Table: writes with masking / ignored addresses, read back
    for (int t = 0; t < 9; t++) begin
      bus_write(tbl[t].addr, tbl[t].wdata);
      bus_read(tbl[t].addr, rd, rc);
      check($sformatf("tbl%0d_rd", t), {32'h0, rd}, {32'h0, tbl[t].exp_rd});
      chk_out($sformatf("tbl%0d_out", t));
    end

    // Simultaneous read and write returns the pre-write value
    old = m_sh[0];
    @(negedge clk);
    avs_if.avs_address = 3'd0; avs_if.avs_writedata = 32'hCAFE0123;
    avs_if.avs_write = 1'b1;   avs_if.avs_read = 1'b1;
    @(posedge clk);
    #1;
    m_apply(3'd0, 32'hCAFE0123, cyc);
    @(negedge clk);
    avs_if.avs_write = 1'b0; avs_if.avs_read = 1'b0;
    check("rw_same_cycle", {32'h0, avs_if.avs_readdata}, {32'h0, old});
    chk_read("rw_after", 3'd0);

    // Blink timing: 10 lit, 10 dark on digit 0
    bus_write(3'd4, 32'h5);
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h0);
    bus_write(3'd3, 32'h0);
    bus_write(3'd0, 32'h12345678);
    bus_write(3'd3, 32'h01);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      check("blink_d0", {56'h0, sevseg_export[7:0]},
            {56'h0, ((((j - 1) / 10) % 2) == 0) ? 8'h80 : 8'hFF});
      check("blink_rest", {8'h0, sevseg_export[63:8]}, {8'h0, 56'hF9A4B0999282F8});
    end
    bus_write(3'd2, 32'h02);
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      check("blank_d1", {56'h0, sevseg_export[15:8]}, 64'hFF);
      check("blank_model", sevseg_export, m_export(m_phase(cyc - 1)));
    end
    chk_read("blink_status", 3'd5);

    // Randomized register traffic against the model
    for (int r = 0; r < 40; r++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 4));
      d = $urandom;
      if (a == 3'd4) d[31] = ($urandom_range(0, 2) != 0);
      bus_write(a, d);
      chk_out("rand_out");
      chk_read("rand_rd", a);
      chk_read("rand_status", 3'd5);
    end

    // Asynchronous reset mid-blink with a pending shadow
    bus_write(3'd4, 32'h5);
    bus_write(3'd3, 32'h0);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd4, 32'h1);
    bus_write(3'd0, 32'h9999);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", sevseg_export, 64'hFFFF_FFFF_FFFF_FFFF);
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(3'd5, rd, rc);
    check("post_reset_status", {32'h0, rd}, 64'h0);
    bus_read(3'd4, rd, rc);
    check("post_reset_ctrl", {32'h0, rd}, 64'h0);
    chk_out("post_reset_out");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_avmm_ctrl.md
Name: sevseg_avmm_ctrl

Overview:
Parametrised seven-segment display controller with an Avalon-MM slave interface. It replaces the fixed-width sevseg_N PIO exports: one instance drives 1..8 digits. It adds hex decode, decimal points, per-digit blank and blink masks, leading-zero suppression, and shadow/active double-buffering. It sits in the Qsys system on the main clock, with segment outputs exported as a conduit to the HEX pins.

Parameters:
NUM_DIGITS, 8, digits driven (legal range 1..8)
CLK_HZ, 50000000, clk_clk frequency in Hz
BLINK_HZ, 2, blink toggle rate; phase period = CLK_HZ/(2*BLINK_HZ) cycles
ACTIVE_LOW, 1, 1 = segment lit when its output bit is 0 (DE2-115 HEX)
SCAN_HZ, 1000, per-digit scan rate (used only with SEVSEG_SCAN_EN)

Ports:
clk_clk  in  1  system clock; the single clock of the block
reset_reset_n  in  1  asynchronous, active-low reset
avs_address  in  3  word address
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data, fixed read latency 1
sevseg_export  out  8*NUM_DIGITS  digit i = bits [8i+7:8i] = {dp,g,f,e,d,c,b,a}

Behaviour:
- Register map:
  - 0 DATA: nibble i = digit i.
  - 1 DP: bit i = decimal point i.
  - 2 BLANK: bit i forces digit i dark.
  - 3 BLINK: bit i blinks digit i.
  - 4 CTRL: bit0 ENABLE, bit1 LZS (leading-zero suppression), bit2 AUTO_COMMIT, bit31 COMMIT (write-only, reads 0).
  - 5 STATUS (read-only): bit0 blink phase, bit1 pending (shadow differs from active).
  - 6, 7: read 0; writes ignored.
- Double-buffering:
  - Writes to regs 0–3 update the shadow copy.
  - Active copy := shadow on the edge after a write with AUTO_COMMIT=1. In that case, on the same edge as the shadow update.
  - Active copy := shadow also on the edge after a CTRL write with bit31=1. CTRL bits 0–2 take the written value on the same edge.
  - Register reads return the shadow copy.
- Bits above the digit count are written as 0:
  - DATA bits at or above 4*NUM_DIGITS.
  - DP/BLANK/BLINK bits at or above NUM_DIGITS.
- Read: avs_readdata is valid on the edge after avs_read; it holds its last value otherwise. Simultaneous read and write: the read returns the pre-write value.
- Digit i is dark when any of these holds:
  - ENABLE=0
  - BLANK[i]=1
  - BLINK[i]=1 and phase=1
  - LZS=1, i>0, and active nibbles i..NUM_DIGITS-1 are all zero (digit 0 is never suppressed by LZS)
- Lit digit: segments = hex7seg(nibble), standard 0–F glyphs; dp = DP[i]. Dark digit: all 8 bits off, including dp.
- Polarity: ACTIVE_LOW inverts all output bits.
- sevseg_export is registered and reflects the active copy one cycle after any active-copy change.
- Blink counter:
  - Counts 0..CLK_HZ/(2*BLINK_HZ)-1, then wraps to 0 and toggles phase.
  - Runs freely, independent of ENABLE.
  - Counter and phase reset to 0 whenever BLINK active transitions from zero to non-zero, so the first dark interval is a full half-period late.
- Reset values:
  - All shadow/active registers 0; CTRL=0; phase=0; counter=0; avs_readdata=0.
  - sevseg_export all off (all ones when ACTIVE_LOW=1).
- Reset mid-operation: asynchronous clear of everything above; no pending commit survives reset.

Optional Feature:
SEVSEG_SCAN_EN
- Defined:
  - Adds output sevseg_digit_sel [NUM_DIGITS-1:0], one-hot, polarity per ACTIVE_LOW.
  - sevseg_export shrinks to 8 bits and carries the selected digit only.
  - A scan counter advances the selection every CLK_HZ/(SCAN_HZ*NUM_DIGITS) cycles, digit 0 upward, wrapping at NUM_DIGITS-1.
  - Reset: selection = digit 0, segments off.
- Undefined: static parallel outputs as described above; no scan logic.

Decomposition:
- Package sevseg_pkg:
  - register address constants (ADDR_DATA..ADDR_STATUS)
  - CTRL bit index constants
  - 16-entry hex-to-segment constant table
  - hex7seg function
- Sub-module sevseg_blink_gen (counter + phase, restart input).
- Top: register file, commit logic, per-digit output mux.

Test Plan:
1. Reset, then CTRL=0x5, DATA=0x12345678 -> two cycles later sevseg_export = glyphs 8,7,6,5,4,3,2,1 digit0..7; for ACTIVE_LOW, digit0 = 8'h80.
2. CTRL=0x1 (no auto-commit), DATA=0x0000ABCD:
   - output unchanged, STATUS.pending=1.
   - Then write CTRL=0x80000001 -> digits A,B,C,D shown, pending=0.
3. CTRL=0x7, DATA=0x00000050 -> digits 0,1 lit (0,5); digits 2–7 all off. DATA=0 -> only digit0 shows "0".
4. CLK_HZ=100, BLINK_HZ=5, BLINK=0x01:
   - digit0 lit 10 cycles, then dark 10 cycles, repeating; other digits steady.
   - BLANK=0x02 -> digit1 dark permanently.
5. DP=0x80, read addr 1 -> readdata=0x80 on the next cycle. Write addr 6 then read addr 6 -> 0.
6. Assert reset_reset_n=0 mid-blink with pending shadow -> outputs off immediately (asynchronously); after release, STATUS=0, CTRL=0.
